// File: rtl/ro_trng_sampler_ctrl.sv
// ro_trng_sampler_ctrl
//   Sequences a bank of ring oscillators for the TRNG: holds them in reset while idle,
//   releases them for a warm-up period, then samples the XOR of their synchronised
//   outputs every SAMPLE_DIV cycles and packs the bits MSB-first into WORD_W-bit words.
//   A run of STUCK_LIM identical sampled bits parks the bank for WARMUP_CYC cycles and
//   then re-warms it automatically.
// Ports
//   CLK, RESET_N  system clock, asynchronous active-low reset
//   START         level enable (1 = generate, 0 = stop and park the ROs)
//   RO_IN         raw RO outputs, asynchronous to CLK
//   RO_RESET      active-high reset to every RO (all bits identical)
//   RAND_DATA     random word, stable while RAND_VALID=1
//   RAND_VALID    word available; RAND_READY accepts it at a CLK edge
//   BUSY          1 in any state other than idle
//   FAULT         sticky stuck-output flag, cleared only by START=0 or reset
//   OVERRUN       one-cycle pulse when a completed word is dropped
module ro_trng_sampler_ctrl #(
    parameter int unsigned NUM_RO     = 8,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned WARMUP_CYC = 64,
    parameter int unsigned SAMPLE_DIV = 16,
    parameter int unsigned STUCK_LIM  = 24
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [NUM_RO-1:0] RO_IN,
    output logic [NUM_RO-1:0] RO_RESET,
    output logic [WORD_W-1:0] RAND_DATA,
    output logic              RAND_VALID,
    input  logic              RAND_READY,
    output logic              BUSY,
    output logic              FAULT,
    output logic              OVERRUN
);

    localparam int unsigned TmrW = $clog2(WARMUP_CYC + 1);
    localparam int unsigned DivW = $clog2(SAMPLE_DIV);
    localparam int unsigned BitW = $clog2(WORD_W);
    localparam int unsigned RunW = $clog2(STUCK_LIM + 1);

    typedef enum logic [1:0] {StIdle, StWarmup, StSample, StFault} state_e;

    state_e              state_q, state_d;
    logic [TmrW-1:0]     tmr_q, tmr_d;
    logic [DivW-1:0]     div_q, div_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0]   shreg_q, shreg_d;
    logic [RunW-1:0]     run_q, run_d, run_next;
    logic                last_bit_q, last_bit_d;
    logic [NUM_RO-1:0]   sync1_q, sync2_q;
    logic [NUM_RO-1:0]   ro_reset_q, ro_reset_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;
    logic                overrun_q, overrun_d;

    logic                sample_bit;
    logic [WORD_W-1:0]   new_word;

    assign sample_bit = ^sync2_q;
    assign new_word   = {shreg_q, sample_bit};

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        run_d      = run_q;
        run_next   = run_q;
        last_bit_d = last_bit_q;
        data_d     = data_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        overrun_d  = 1'b0;

        // Consumer handshake; a word loaded below on the same edge re-asserts valid.
        if (valid_q && RAND_READY) begin
            valid_d = 1'b0;
        end

        if (!START) begin
            // Park everything; a pending output word survives until accepted.
            state_d   = StIdle;
            tmr_d     = '0;
            div_d     = '0;
            bit_cnt_d = '0;
            run_d     = '0;
            fault_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StWarmup;
                    tmr_d   = '0;
                end
                StWarmup: begin
                    if (tmr_q == TmrW'(WARMUP_CYC - 1)) begin
                        state_d   = StSample;
                        tmr_d     = '0;
                        div_d     = '0;
                        bit_cnt_d = '0;
                        run_d     = '0;
                    end else begin
                        tmr_d = tmr_q + TmrW'(1);
                    end
                end
                StSample: begin
                    if (div_q == DivW'(SAMPLE_DIV - 1)) begin
                        div_d      = '0;
                        shreg_d    = new_word[WORD_W-2:0];
                        last_bit_d = sample_bit;
                        // run_q == 0 means no bit taken yet in this run
                        if (run_q != '0 && sample_bit == last_bit_q) begin
                            run_next = run_q + RunW'(1);
                        end else begin
                            run_next = RunW'(1);
                        end
                        if (bit_cnt_q == BitW'(WORD_W - 1)) begin
                            bit_cnt_d = '0;
                            if (!valid_q || RAND_READY) begin
                                data_d  = new_word;
                                valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                        if (run_next == RunW'(STUCK_LIM)) begin
                            state_d   = StFault;
                            tmr_d     = '0;
                            bit_cnt_d = '0;
                            run_d     = '0;
                            fault_d   = 1'b1;
                        end else begin
                            run_d = run_next;
                        end
                    end else begin
                        div_d = div_q + DivW'(1);
                    end
                end
                StFault: begin
                    if (tmr_q == TmrW'(WARMUP_CYC - 1)) begin
                        state_d = StWarmup;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TmrW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        ro_reset_d = {NUM_RO{(state_d == StIdle) || (state_d == StFault)}};
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            tmr_q      <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            run_q      <= '0;
            last_bit_q <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            ro_reset_q <= '1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            run_q      <= run_d;
            last_bit_q <= last_bit_d;
            sync1_q    <= RO_IN;
            sync2_q    <= sync1_q;
            ro_reset_q <= ro_reset_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            overrun_q  <= overrun_d;
        end
    end

    assign RO_RESET   = ro_reset_q;
    assign RAND_DATA  = data_q;
    assign RAND_VALID = valid_q;
    assign BUSY       = busy_q;
    assign FAULT      = fault_q;
    assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_ro_trng_sampler_ctrl.sv
// Bench for ro_trng_sampler_ctrl with NUM_RO=2, WORD_W=8, WARMUP_CYC=4, SAMPLE_DIV=2,
// STUCK_LIM=6. Each run plans its sampled bit sequence up front; RO_IN is driven so the
// XOR seen at each sample point (two cycles of synchroniser delay) equals the planned bit.
// Edge e0 is the edge that first sees START=1: samples land at e0+4+2i, words complete
// at e0+4+16j.
module tb_ro_trng_sampler_ctrl;

    logic       clk, rst_n, start, ready;
    logic [1:0] ro_in, ro_reset;
    logic [7:0] rdata;
    logic       valid, busy, fault, overrun;

    int vectors     = 0;
    int miscompares = 0;
    int ecount      = 0;
    int e0          = 0;
    bit plan_on     = 0;
    bit hold_ro     = 0;
    logic pbits[64];
    logic pr[64];

    // Output-slot model state for the random-ready run
    logic       exp_v;
    logic [7:0] exp_d;
    logic       exp_o;
    int         rel;

    ro_trng_sampler_ctrl #(
        .NUM_RO    (2),
        .WORD_W    (8),
        .WARMUP_CYC(4),
        .SAMPLE_DIV(2),
        .STUCK_LIM (6)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .START     (start),
        .RO_IN     (ro_in),
        .RO_RESET  (ro_reset),
        .RAND_DATA (rdata),
        .RAND_VALID(valid),
        .RAND_READY(ready),
        .BUSY      (busy),
        .FAULT     (fault),
        .OVERRUN   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive RO_IN for the upcoming edge, then advance one edge and settle.
    task automatic tick();
        int n, idx;
        n = ecount + 1;
        if (plan_on && n >= e0 + 4) begin
            idx = (n - e0 - 4) / 2;
            if (idx < 64) ro_in = {pr[idx], pr[idx] ^ pbits[idx]};
        end else if (!hold_ro) begin
            ro_in = 2'($urandom);
        end
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic tick_to(input int target);
        while (ecount < target) tick();
    endtask

    // Random bit plan with no run of 6 equal bits; optionally first word = 8'hB2.
    task automatic make_plan(input bit directed);
        logic [7:0] d;
        logic       last, b;
        int         run;
        d = 8'hB2;
        run = 0;
        last = 1'b0;
        for (int i = 0; i < 64; i++) begin
            b = (directed && i < 8) ? d[7-i] : 1'($urandom);
            if (run == 5 && b == last) b = ~last;
            if (run > 0 && b == last) run++;
            else run = 1;
            last = b;
            pbits[i] = b;
            pr[i] = 1'($urandom);
        end
    endtask

    function automatic logic [7:0] word_of(input int j);
        logic [7:0] w;
        for (int b = 0; b < 8; b++) w[7-b] = pbits[(j-1)*8 + b];
        return w;
    endfunction

    task automatic begin_run(input bit directed);
        make_plan(directed);
        hold_ro = 0;
        start = 1'b1;
        e0 = ecount + 1;
        plan_on = 1;
        tick();
    endtask

    task automatic stop_run();
        start = 1'b0;
        plan_on = 0;
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ro_reset"}, 32'(ro_reset), 32'd3);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_data"}, 32'(rdata), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b1;
        ready = 1'b0;
        ro_in = 2'b00;
        hold_ro = 1;
        #1 rst_n = 1'b0;
        #1;
        // 1: reset holds with START=1 and RO_IN toggling
        chk_reset_outputs("rst_pre");
        for (int i = 0; i < 3; i++) begin
            ro_in = ~ro_in;
            tick();
            chk_reset_outputs("rst_hold");
        end
        rst_n = 1'b1;
        start = 1'b0;
        hold_ro = 0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ro_reset", 32'(ro_reset), 32'd3);

        // 2: directed data path, first word 8'hB2 after 1+4+16 cycles
        ready = 1'b1;
        begin_run(1);
        chk("dp_busy", 32'(busy), 32'd1);
        chk("dp_ro_reset", 32'(ro_reset), 32'd0);
        tick_to(e0 + 19);
        chk("dp_valid_early", 32'(valid), 32'd0);
        tick();
        chk("dp_valid", 32'(valid), 32'd1);
        chk("dp_data", 32'(rdata), 32'hB2);
        chk("dp_overrun", 32'(overrun), 32'd0);
        tick();
        chk("dp_valid_drop", 32'(valid), 32'd0);
        stop_run();

        // 3: stuck output -> FAULT after 6th sample, parked 4 cycles, auto re-warm
        ready = 1'b0;
        hold_ro = 1;
        ro_in = 2'b11;
        start = 1'b1;
        e0 = ecount + 1;
        plan_on = 0;
        tick();
        tick_to(e0 + 15);
        chk("st_fault_early", 32'(fault), 32'd0);
        tick();
        chk("st_fault", 32'(fault), 32'd1);
        chk("st_ro_reset0", 32'(ro_reset), 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_ro_reset_hold", 32'(ro_reset), 32'd3);
        end
        tick();
        chk("st_rewarm_ro_reset", 32'(ro_reset), 32'd0);
        chk("st_rewarm_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("st_fault_sticky", 32'(fault), 32'd1);
        end
        chk("st_no_valid", 32'(valid), 32'd0);
        start = 1'b0;
        tick();
        chk("st_clear_fault", 32'(fault), 32'd0);
        chk("st_clear_busy", 32'(busy), 32'd0);
        chk("st_clear_ro_reset", 32'(ro_reset), 32'd3);
        hold_ro = 0;

        // 4: backpressure, overrun on second word, load-through on third
        ready = 1'b0;
        begin_run(0);
        tick_to(e0 + 20);
        chk("bp_w1_valid", 32'(valid), 32'd1);
        chk("bp_w1_data", 32'(rdata), 32'(word_of(1)));
        chk("bp_w1_ovr", 32'(overrun), 32'd0);
        tick_to(e0 + 36);
        chk("bp_w2_ovr", 32'(overrun), 32'd1);
        chk("bp_w2_valid", 32'(valid), 32'd1);
        chk("bp_w2_data", 32'(rdata), 32'(word_of(1)));
        tick();
        chk("bp_ovr_pulse", 32'(overrun), 32'd0);
        chk("bp_hold_data", 32'(rdata), 32'(word_of(1)));
        tick_to(e0 + 51);
        ready = 1'b1;
        tick();
        chk("bp_w3_valid", 32'(valid), 32'd1);
        chk("bp_w3_data", 32'(rdata), 32'(word_of(3)));
        chk("bp_w3_ovr", 32'(overrun), 32'd0);
        tick();
        chk("bp_w3_accept", 32'(valid), 32'd0);
        ready = 1'b0;
        stop_run();

        // 5: stop after 3 samples, restart yields a fresh full word
        ready = 1'b1;
        begin_run(0);
        tick_to(e0 + 10);
        stop_run();
        chk("sm_busy", 32'(busy), 32'd0);
        chk("sm_ro_reset", 32'(ro_reset), 32'd3);
        repeat (3) tick();
        chk("sm_valid_idle", 32'(valid), 32'd0);
        begin_run(0);
        tick_to(e0 + 19);
        chk("sm_valid_early", 32'(valid), 32'd0);
        tick();
        chk("sm_valid", 32'(valid), 32'd1);
        chk("sm_data", 32'(rdata), 32'(word_of(1)));
        stop_run();
        chk("sm_drained", 32'(valid), 32'd0);

        // 7: random READY against an output-slot model over five words
        ready = 1'b0;
        exp_v = 1'b0;
        exp_d = 8'h00;
        begin_run(0);
        while (ecount < e0 + 4 + 16 * 5 + 3) begin
            ready = 1'($urandom);
            rel = ecount + 1 - e0 - 4;
            exp_o = 1'b0;
            if (rel > 0 && rel % 16 == 0) begin
                if (!exp_v || ready) begin
                    exp_d = word_of(rel / 16);
                    exp_v = 1'b1;
                end else begin
                    exp_o = 1'b1;
                end
            end else if (exp_v && ready) begin
                exp_v = 1'b0;
            end
            tick();
            chk("rr_valid", 32'(valid), 32'(exp_v));
            chk("rr_overrun", 32'(overrun), 32'(exp_o));
            if (exp_v) chk("rr_data", 32'(rdata), 32'(exp_d));
        end
        ready = 1'b1;
        stop_run();

        // 6: async reset mid-SAMPLE with a word pending
        ready = 1'b0;
        begin_run(0);
        tick_to(e0 + 23);
        chk("ar_valid_before", 32'(valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs("ar");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
